serial_magnitude_comparator: RTL

//   Parametrised, multi-cycle magnitude comparator; successor to the 2-bit combinational comparator.

---
 rtl/serial_magnitude_comparator_if.sv | 24 ++
 rtl/serial_magnitude_comparator.sv | 121 ++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator_if.sv
// Operand/result bundle for serial_magnitude_comparator; the requester owns start/x/y,
// the comparator owns busy/done and the gt/eq/lt flags.
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, x, y,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, x, y,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial magnitude compare, SLICE bits per clock; done pulses NSLICE (or first-difference) edges after start.
// start is ignored while busy. Define CMP_SIGNED_EN for a two's-complement compare.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 8,
    parameter int SLICE      = 2,
    parameter int EARLY_EXIT = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dgt_q, dgt_d;
    logic             dlt_q, dlt_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [SLICE-1:0] xa, ya;
    logic [WIDTH-1:0] cap_x, cap_y;
    logic             dgt_nxt, dlt_nxt, last_slice;

    assign xa = xs_q[WIDTH-1 -: SLICE];
    assign ya = ys_q[WIDTH-1 -: SLICE];

`ifdef CMP_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    assign cap_x = bus.x ^ MSB_MASK;
    assign cap_y = bus.y ^ MSB_MASK;
`else
    assign cap_x = bus.x;
    assign cap_y = bus.y;
`endif

    // Only the first differing slice decides; later slices are ignored.
    assign dgt_nxt    = dgt_q | (~dgt_q & ~dlt_q & (xa > ya));
    assign dlt_nxt    = dlt_q | (~dgt_q & ~dlt_q & (xa < ya));
    assign last_slice = (cnt_q == CW'(NSLICE - 1));

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        cnt_d   = cnt_q;
        dgt_d   = dgt_q;
        dlt_d   = dlt_q;
        done_d  = 1'b0;
        gt_d    = gt_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    xs_d    = cap_x;
                    ys_d    = cap_y;
                    cnt_d   = '0;
                    dgt_d   = 1'b0;
                    dlt_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                xs_d  = xs_q << SLICE;
                ys_d  = ys_q << SLICE;
                cnt_d = cnt_q + CW'(1);
                dgt_d = dgt_nxt;
                dlt_d = dlt_nxt;
                if (last_slice || ((EARLY_EXIT != 0) && (dgt_nxt || dlt_nxt))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    gt_d    = dgt_nxt;
                    lt_d    = dlt_nxt;
                    eq_d    = ~(dgt_nxt | dlt_nxt);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            cnt_q   <= '0;
            dgt_q   <= 1'b0;
            dlt_q   <= 1'b0;
            done_q  <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            cnt_q   <= cnt_d;
            dgt_q   <= dgt_d;
            dlt_q   <= dlt_d;
            done_q  <= done_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;
endmodule
